// File: rtl/gf2m_pkg.sv
// Shared constants, state encoding and element type for the digit-serial GF(2^M) multiplier.
package gf2m_pkg;

    localparam int unsigned   GF_M    = 163;
    localparam int unsigned   GF_D    = 4;
    localparam int unsigned   GF_N    = (GF_M + GF_D - 1) / GF_D;
    localparam logic [162:0]  GF_POLY = 163'hC9;

    typedef logic [GF_M-1:0] gf_elem_t;

    // ST_HOLD is only entered when the extra output register stage is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } mul_state_t;

endpackage

// File: rtl/gf2m_mul_step.sv
// One combinational digit step: (acc*x^D xor a*digit) mod f, evaluated Horner-style MSB first.
module gf2m_mul_step #(
    parameter int unsigned M    = 163,
    parameter int unsigned D    = 4,
    parameter logic [M-1:0] POLY = 163'hC9
) (
    input  logic [M-1:0] i_acc,
    input  logic [M-1:0] i_a,
    input  logic [D-1:0] i_digit,
    output logic [M-1:0] o_res
);

    logic [M-1:0] w_r;

    // Each pass multiplies by x (folding x^M back as POLY) then adds a if the digit bit is set.
    always_comb begin
        w_r = i_acc;
        for (int unsigned j = 0; j < D; j++) begin
            w_r = {w_r[M-2:0], 1'b0} ^ (w_r[M-1] ? POLY : '0);
            if (i_digit[D-1-j]) begin
                w_r = w_r ^ i_a;
            end
        end
        o_res = w_r;
    end

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) multiplier (MUL1 port). Define GF2M_MUL_OUT_REG_EN for one extra output stage.
module gf2m_digit_mul
    import gf2m_pkg::*;
#(
    parameter int unsigned  M    = GF_M,
    parameter int unsigned  D    = GF_D,
    parameter logic [M-1:0] POLY = GF_POLY
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         OUT_VALID,
    output logic [M-1:0] C,
    output logic         BUSY,
    output logic         ERROR
);

    localparam int unsigned N  = (M + D - 1) / D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = N * D;

    mul_state_t     r_state;
    logic [M-1:0]   r_a;
    logic [BW-1:0]  r_b_sh;
    logic [M-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [M-1:0]   r_c;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_error;
    logic [M-1:0]   w_step;
    logic [D-1:0]   w_digit;

    assign w_digit = r_b_sh[BW-1 -: D];

    gf2m_mul_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .i_acc   (r_acc),
        .i_a     (r_a),
        .i_digit (w_digit),
        .o_res   (w_step)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b_sh      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_c         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_error     <= IN_VALID && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        r_a     <= A;
                        r_b_sh  <= BW'(B);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc  <= w_step;
                    r_b_sh <= r_b_sh << D;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef GF2M_MUL_OUT_REG_EN
                    r_state <= ST_HOLD;
`else
                    r_c         <= r_acc;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
`endif
                end
                ST_HOLD: begin
`ifdef GF2M_MUL_OUT_REG_EN
                    // acc is frozen after RUN, so it serves as the pipeline register here.
                    r_c         <= r_acc;
                    r_out_valid <= 1'b1;
`endif
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign OUT_VALID = r_out_valid;
    assign C         = r_c;
    assign BUSY      = r_busy;
    assign ERROR     = r_error;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Scoreboard bench for gf2m_digit_mul; honours GF2M_MUL_OUT_REG_EN for the expected latency.
module tb_gf2m_digit_mul;

    localparam int M = 163;
`ifdef GF2M_MUL_OUT_REG_EN
    localparam int LAT = 43;
`else
    localparam int LAT = 42;
`endif

    logic         CLK;
    logic         RST_N;
    logic         IN_VALID;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         OUT_VALID;
    logic [M-1:0] C;
    logic         BUSY;
    logic         ERROR;

    gf2m_digit_mul #(
        .M    (163),
        .D    (4),
        .POLY (163'hC9)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .C         (C),
        .BUSY      (BUSY),
        .ERROR     (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [M-1:0] c;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc     = 0;
    int   err_due = -1;
    int   n_cmp   = 0;
    int   n_mis   = 0;

    always @(posedge CLK) cyc = cyc + 1;

    // LSB-first shift-and-add reference multiplier.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            t = t[M-1] ? ({t[M-2:0], 1'b0} ^ 163'hC9) : {t[M-2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rnd163();
        logic [191:0] w;
        for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
        return w[M-1:0];
    endfunction

    task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller must be positioned at a negedge; returns one negedge later.
    task automatic issue(input logic [M-1:0] a, input logic [M-1:0] b);
        exp_t e;
        IN_VALID = 1'b1;
        A = a;
        B = b;
        e.c   = gf_mul(a, b);
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_ov(input int budget);
        int k;
        k = 0;
        while (!OUT_VALID && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("out_valid_timeout", OUT_VALID, 1);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() > 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Result/latency/ERROR monitor, sampled just after each active edge.
    always @(posedge CLK) begin
        #1;
        chk("error", ERROR, (cyc == err_due) ? 1 : 0);
        if (OUT_VALID) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", OUT_VALID, 0);
            end else begin
                m_e = sb.pop_front();
                chk("product", C, m_e.c);
                chk("latency", cyc, m_e.due);
                chk("busy_in_out_cycle", BUSY, 0);
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missing_out_valid", OUT_VALID, 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        logic [M-1:0] top_bit;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        A        = '0;
        B        = '0;
        repeat (3) @(negedge CLK);
        chk("reset_c", C, 0);
        chk("reset_out_valid", OUT_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_error", ERROR, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        issue(163'd1, 163'd1);
        drain(80);

        top_bit = 163'd1 << 162;
        issue(top_bit, 163'd2);
        drain(80);
        issue('0, rnd163());
        drain(80);
        issue('1, '1);
        drain(80);

        // Request during RUN: ERROR next cycle, ignored, first result unaffected.
        issue(rnd163(), rnd163());
        repeat (9) @(negedge CLK);
        IN_VALID = 1'b1;
        A = rnd163();
        B = rnd163();
        err_due = cyc + 1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("busy_during_run", BUSY, 1);
        drain(80);
        repeat (50) @(negedge CLK);

        // Back-to-back issue in the OUT_VALID cycle.
        issue(rnd163(), rnd163());
        wait_ov(80);
        issue(rnd163(), rnd163());
        drain(80);

        // Reset mid-operation.
        issue(rnd163(), rnd163());
        repeat (19) @(negedge CLK);
        RST_N = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("abort_c", C, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_out_valid", OUT_VALID, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        issue(rnd163(), rnd163());
        drain(80);

        for (int i = 0; i < 1000; i++) begin
            issue(rnd163(), rnd163());
            wait_ov(80);
        end
        drain(80);
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gf2m_digit_mul.md
# gf2m_digit_mul

Digit-serial GF(2^M) multiplier for binary-field ECC point arithmetic. It consumes one-cycle IN_VALID pulses and operand pairs from the point-arithmetic control FSMs (the "MUL1" port). It returns the reduced product C = A·B mod f(x) with a one-cycle OUT_VALID pulse. It also reports protocol violations on ERROR, which feeds the FSM's ERROR inputs.

## Interface
- M, 163, field degree
- D, 4, digit width (bits of B consumed per cycle); 1 ≤ D ≤ M
- POLY, 163'hC9, low part of the reduction polynomial, f(x) = x^M + POLY (default x^163+x^7+x^6+x^3+1)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- IN_VALID  in  1  start pulse; A and B are sampled on the same edge
- A  in  M  operand A, polynomial basis, bit i = coeff of x^i
- B  in  M  operand B
- OUT_VALID  out  1  one-cycle pulse; C is valid from this cycle
- C  out  M  product A·B mod f; held until the next result or reset
- BUSY  out  1  high while an operation is in progress (RUN or DONE)
- ERROR  out  1  one-cycle pulse when IN_VALID arrives while BUSY

## Operation
- N = ceil(M/D) digits (41 by default). B is zero-extended to N·D bits and processed most-significant digit first.
- **IDLE:**
  - IN_VALID=1: capture A into a_reg and the padded B into b_sh; clear acc; set cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- **RUN:**
  - Each cycle: acc ← (acc·x^D mod f) ⊕ (a_reg·b_sh[top D bits] mod f); shift b_sh left by D; cnt++.
  - After N iterations (cnt==N-1 on that edge), go to DONE.
- **DONE:** register C ← acc and set OUT_VALID=1; go to IDLE.
- **Arithmetic:**
  - All addition is XOR; there is no carry.
  - Reduction by x^M ≡ POLY is applied inside each step, so acc is always < x^M.
  - Inputs with any value are legal; C is always fully reduced.
- **ERROR:**
  - IN_VALID=1 while in RUN or DONE gives ERROR=1 on the next cycle.
  - The request is ignored, and the in-flight operation and C are unaffected.
- **Reset values:** OUT_VALID=0, ERROR=0, BUSY=0, C=0. Internal state: IDLE, acc=0, cnt=0.
- Reset mid-operation aborts immediately; no OUT_VALID is produced for the aborted operation.

## Timing
- Latency: IN_VALID sampled at edge t0 → OUT_VALID=1 and C valid in the cycle after edge t0+N+1, i.e. N+1 cycles (42 by default).
- OUT_VALID is high for exactly one cycle.
- BUSY:
  - high from the cycle after t0 through the DONE cycle;
  - low in the cycle where OUT_VALID is high.
- Back-to-back: the upstream FSM may assert IN_VALID in the same cycle OUT_VALID is high. It is accepted (state is IDLE), with no ERROR. Issue period is N+1 cycles.
- IN_VALID held high for several cycles counts as one start plus ERROR on each subsequent cycle while BUSY. Upstream must pulse it.
- C changes only on the OUT_VALID edge or on reset.

## Configuration
- GF2M_MUL_OUT_REG_EN defined:
  - adds one pipeline register after DONE for C and OUT_VALID;
  - latency becomes N+2;
  - BUSY stays high through that extra cycle;
  - IN_VALID is accepted only once OUT_VALID is high.
- GF2M_MUL_OUT_REG_EN undefined: latency N+1 as specified above.

## Structure
- Shared package gf2m_pkg:
  - M, D, N, and POLY constants;
  - the state encoding (IDLE, RUN, DONE);
  - the element type (M-bit vector).
- One combinational sub-module, gf2m_mul_step: inputs acc, a, digit[D-1:0]; output (acc·x^D ⊕ a·digit) mod f. The multiplier core is the FSM, counter and shift register around it.
- The PV and ladder FSMs instantiate gf2m_digit_mul for MUL1.

## Test plan
- A=1, B=1, IN_VALID pulse → after 42 cycles OUT_VALID pulse, C=1, ERROR never set.
- A=1<<162, B=2 → C=163'hC9 (x^163 reduced); A=0, B=random → C=0.
- IN_VALID at cycle 10 of a run → ERROR=1 one cycle later; first result unchanged and still arrives at cycle 42; no second OUT_VALID.
- Back-to-back: IN_VALID asserted in the OUT_VALID cycle with new operands → second OUT_VALID exactly 42 cycles later with the correct product; ERROR=0.
- RST_N=0 at cycle 20 of a run → next cycle C=0, BUSY=0, OUT_VALID=0; a new request after reset completes normally.
- 1000 random A/B pairs against a software GF(2^163) model, with and without GF2M_MUL_OUT_REG_EN (latency 42 / 43).
